// File: rtl/instruction_sequencer_if.sv
// Instruction sequencer bus: instruction handshake in, ALU/PC controls out.
//
// Handshake: the master holds opcode/operand stable while instr_valid is high;
// an instruction transfers on a rising clk edge where instr_valid && instr_ready.
// instr_ready depends only on sequencer state, never on instr_valid.
// state_dbg mirrors the sequencer FSM state encoding for observation only.
interface instruction_sequencer_if #(
    parameter int OPCODE_WIDTH = 3,
    parameter int REG_COUNT    = 5,
    parameter int WAIT_WIDTH   = 4
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [WAIT_WIDTH-1:0]   operand;
    logic                    instr_valid;
    logic                    instr_ready;
    logic                    ALU_add;
    logic                    ALU_load;
    logic                    wr_res;
    logic                    PC_wait;
    logic [REG_COUNT-1:0]    ALU_reg_en;
    logic                    busy;
    logic                    illegal_op;
    logic [2:0]              state_dbg;

    // Instruction source / control consumer side
    modport master (
        output opcode, operand, instr_valid,
        input  instr_ready, ALU_add, ALU_load, wr_res, PC_wait, ALU_reg_en,
        input  busy, illegal_op, state_dbg
    );

    // Sequencer side
    modport slave (
        input  opcode, operand, instr_valid,
        output instr_ready, ALU_add, ALU_load, wr_res, PC_wait, ALU_reg_en,
        output busy, illegal_op, state_dbg
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: decodes one instruction at a time into registered
// ALU/PC control pulses. MOV/MAC/SETB/SETD/SETE take one EXEC cycle, LDSW
// takes LD then WR, WAIT holds PC_wait for max(operand,1) cycles.
// A new instruction may be accepted in the final cycle of the current one,
// so consecutive instructions run with no idle bubble.
//
// Optional feature macro: INSTR_SEQ_ILLEGAL_TRAP_EN
//   defined   : an undefined opcode traps into HALT (illegal_op sticky,
//               instr_ready low) until rst.
//   undefined : an undefined opcode runs as a one-cycle EXEC NOP with
//               illegal_op high for that cycle only.
//
// Opcode encodings (shared opcode definitions):
//   MOV=0 MAC=1 SETB=2 SETD=3 SETE=4 WAIT=5 LDSW=6, anything else undefined.
// REG_COUNT must be 5 or greater (bits 0..4 carry named register enables).
module instruction_sequencer #(
    parameter int OPCODE_WIDTH = 3,
    parameter int REG_COUNT    = 5,
    parameter int WAIT_WIDTH   = 4
) (
    input logic                   clk,
    input logic                   rst,
    instruction_sequencer_if.slave bus
);

    localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_MAC  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETB = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETD = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SETE = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDSW = OPCODE_WIDTH'(6);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WAIT = 3'd2,
        S_LD   = 3'd3,
        S_WR   = 3'd4
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
        , S_HALT = 3'd5
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic [WAIT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                    alu_add_q, alu_add_d;
    logic                    alu_load_q, alu_load_d;
    logic                    wr_res_q, wr_res_d;
    logic                    pc_wait_q, pc_wait_d;
    logic [REG_COUNT-1:0]    reg_en_q, reg_en_d;
    logic                    illegal_op_q, illegal_op_d;

    logic                    final_cycle;
    logic                    accept;
    logic                    op_legal;

    // Final cycle of the current activity: the only cycles that take a new instruction
    always_comb begin
        final_cycle = 1'b0;
        case (state_q)
            S_IDLE, S_EXEC, S_WR: final_cycle = 1'b1;
            S_WAIT:               final_cycle = (cnt_q == WAIT_WIDTH'(1));
            default:              final_cycle = 1'b0;
        endcase
    end

    assign accept   = bus.instr_valid && final_cycle;
    assign op_legal = bus.opcode inside {OP_MOV, OP_MAC, OP_SETB, OP_SETD,
                                         OP_SETE, OP_WAIT, OP_LDSW};

    // Next-state and WAIT counter: dispatch on accept, otherwise advance or retire
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (final_cycle) begin
            if (accept) begin
                if (bus.opcode == OP_WAIT) begin
                    state_d = S_WAIT;
                    // A zero operand still waits one cycle
                    cnt_d   = (bus.operand == '0) ? WAIT_WIDTH'(1) : bus.operand;
                end else if (bus.opcode == OP_LDSW) begin
                    state_d = S_LD;
                end else if (!op_legal) begin
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_EXEC;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_LD: state_d = S_WR;
                S_WAIT: begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q - WAIT_WIDTH'(1);
                end
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
                S_HALT: state_d = S_HALT;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control outputs for the state being entered; EXEC is only ever entered
    // through an accept, so the live opcode is the one being dispatched
    always_comb begin
        alu_add_d    = 1'b0;
        alu_load_d   = 1'b0;
        wr_res_d     = 1'b0;
        pc_wait_d    = 1'b0;
        reg_en_d     = '0;
        illegal_op_d = 1'b0;
        case (state_d)
            S_EXEC: begin
                case (bus.opcode)
                    OP_MOV: begin
                        alu_add_d = 1'b1;
                        wr_res_d  = 1'b1;
                        reg_en_d  = '1;
                    end
                    OP_MAC: begin
                        wr_res_d    = 1'b1;
                        reg_en_d[0] = 1'b1;
                        reg_en_d[2] = 1'b1;
                    end
                    OP_SETB: reg_en_d[1] = 1'b1;
                    OP_SETD: reg_en_d[3] = 1'b1;
                    OP_SETE: reg_en_d[4] = 1'b1;
                    // Undefined opcode executed as a NOP
                    default: illegal_op_d = 1'b1;
                endcase
            end
            S_WAIT: pc_wait_d = 1'b1;
            S_LD: begin
                alu_load_d = 1'b1;
                reg_en_d   = '1;
            end
            S_WR: begin
                alu_add_d = 1'b1;
                wr_res_d  = 1'b1;
                reg_en_d  = '1;
            end
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
            S_HALT: illegal_op_d = 1'b1;
`endif
            default: ;
        endcase
    end

    // State, counter and output registers; rst wins over any accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_add_q    <= 1'b0;
            alu_load_q   <= 1'b0;
            wr_res_q     <= 1'b0;
            pc_wait_q    <= 1'b0;
            reg_en_q     <= '0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_add_q    <= alu_add_d;
            alu_load_q   <= alu_load_d;
            wr_res_q     <= wr_res_d;
            pc_wait_q    <= pc_wait_d;
            reg_en_q     <= reg_en_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.instr_ready = final_cycle;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.ALU_add     = alu_add_q;
    assign bus.ALU_load    = alu_load_q;
    assign bus.wr_res      = wr_res_q;
    assign bus.PC_wait     = pc_wait_q;
    assign bus.ALU_reg_en  = reg_en_q;
    assign bus.illegal_op  = illegal_op_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer. The reference model is a queue of expected
// per-cycle output words: each accepted instruction appends the cycles it
// must produce, and a new instruction may be taken while at most one cycle
// remains. Directed vectors add literal checks on top.
module tb_instruction_sequencer;
  localparam int OW = 3;
  localparam int RC = 5;
  localparam int WW = 4;
  localparam int EW = RC + 5;  // {ill, add, load, wr, pcw, en}

  localparam int OP_MOV = 0, OP_MAC = 1, OP_SETB = 2, OP_SETD = 3;
  localparam int OP_SETE = 4, OP_WAIT = 5, OP_LDSW = 6, OP_BAD = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_sequencer_if #(.OPCODE_WIDTH(OW), .REG_COUNT(RC), .WAIT_WIDTH(WW)) bus ();

  instruction_sequencer #(.OPCODE_WIDTH(OW), .REG_COUNT(RC), .WAIT_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  bit            halted = 1'b0;
  int            acc_count = 0;
  bit            chk_en = 1'b0;
  int            tests_run = 0;
  int            failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit ill, input bit add, input bit ld,
                                       input bit wr, input bit pcw, input int en);
    logic [RC-1:0] e;
    e = RC'(en);
    return {ill, add, ld, wr, pcw, e};
  endfunction

  // Expected cycles of one instruction, from the opcode table
  function automatic void push_instr(input int op, input int opd);
    int n;
    case (op)
      OP_MOV:  exp_q.push_back(mk(0, 1, 0, 1, 0, (1 << RC) - 1));
      OP_MAC:  exp_q.push_back(mk(0, 0, 0, 1, 0, 5));
      OP_SETB: exp_q.push_back(mk(0, 0, 0, 0, 0, 2));
      OP_SETD: exp_q.push_back(mk(0, 0, 0, 0, 0, 8));
      OP_SETE: exp_q.push_back(mk(0, 0, 0, 0, 0, 16));
      OP_WAIT: begin
        n = (opd == 0) ? 1 : opd;
        for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
      end
      OP_LDSW: begin
        exp_q.push_back(mk(0, 0, 1, 0, 0, (1 << RC) - 1));
        exp_q.push_back(mk(0, 1, 0, 1, 0, (1 << RC) - 1));
      end
      default: begin
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
        halted = 1'b1;
`else
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
`endif
      end
    endcase
  endfunction

  // Model update at each clock edge
  always @(posedge clk) begin : model
    bit m_ready;
    if (rst) begin
      exp_q.delete();
      halted = 1'b0;
    end else begin
      m_ready = !halted && (exp_q.size() <= 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (bus.instr_valid && m_ready) begin
        acc_count++;
        push_instr(int'(bus.opcode), int'(bus.operand));
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin : compare
    logic [EW-1:0] e;
    logic [EW+1:0] exp_v, act_v;
    if (chk_en) begin
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      if (halted) e[EW-1] = 1'b1;
      exp_v = {(!halted && exp_q.size() <= 1), (halted || exp_q.size() > 0), e};
      act_v = {bus.instr_ready, bus.busy, bus.illegal_op, bus.ALU_add, bus.ALU_load,
               bus.wr_res, bus.PC_wait, bus.ALU_reg_en};
      check("cycle", 32'(act_v), 32'(exp_v));
    end
  end

  // ---------------- driver tasks ----------------
  // Present an instruction and return at the negedge of its first output cycle
  task automatic send(input int op, input int opd);
    int start;
    start = acc_count;
    bus.instr_valid = 1'b1;
    bus.opcode      = OW'(op);
    bus.operand     = WW'(opd);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_count != start) break;
    end
    check("accept", 32'(acc_count - start), 32'd1);
    bus.instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.opcode = '0;
    bus.operand = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_ready", bus.instr_ready, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_en", bus.ALU_reg_en, 0);

    // MOV: one cycle of add/wr/all enables, then quiet
    send(OP_MOV, 0);
    check("mov_add", bus.ALU_add, 1);
    check("mov_wr", bus.wr_res, 1);
    check("mov_en", bus.ALU_reg_en, 5'b11111);
    @(negedge clk);
    check("mov_after_en", bus.ALU_reg_en, 0);
    check("mov_after_busy", bus.busy, 0);

    // WAIT 3 with MAC held valid behind it
    send(OP_WAIT, 3);
    check("w3_c1_pcw", bus.PC_wait, 1);
    check("w3_c1_rdy", bus.instr_ready, 0);
    bus.instr_valid = 1'b1;
    bus.opcode = OW'(OP_MAC);
    @(negedge clk);
    check("w3_c2_pcw", bus.PC_wait, 1);
    check("w3_c2_rdy", bus.instr_ready, 0);
    @(negedge clk);
    check("w3_c3_pcw", bus.PC_wait, 1);
    check("w3_c3_rdy", bus.instr_ready, 1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("mac_pcw", bus.PC_wait, 0);
    check("mac_wr", bus.wr_res, 1);
    check("mac_en", bus.ALU_reg_en, 5'b00101);
    check("mac_add", bus.ALU_add, 0);
    idle(1);

    // WAIT 0 behaves as one cycle
    send(OP_WAIT, 0);
    check("w0_pcw", bus.PC_wait, 1);
    check("w0_rdy", bus.instr_ready, 1);
    @(negedge clk);
    check("w0_after_pcw", bus.PC_wait, 0);

    // LDSW: LD then WR
    send(OP_LDSW, 0);
    check("ld_load", bus.ALU_load, 1);
    check("ld_wr", bus.wr_res, 0);
    check("ld_rdy", bus.instr_ready, 0);
    @(negedge clk);
    check("wr_add", bus.ALU_add, 1);
    check("wr_wr", bus.wr_res, 1);
    check("wr_load", bus.ALU_load, 0);
    idle(1);

    // Back-to-back sequence with no gaps
    send(OP_MOV, 0);
    send(OP_SETB, 0);
    check("setb_en", bus.ALU_reg_en, 5'b00010);
    send(OP_SETD, 0);
    check("setd_en", bus.ALU_reg_en, 5'b01000);
    send(OP_SETE, 0);
    check("sete_en", bus.ALU_reg_en, 5'b10000);
    send(OP_MAC, 0);
    send(OP_LDSW, 0);
    send(OP_WAIT, 2);
    send(OP_MOV, 0);
    idle(2);

    // Opcode/operand changes while not valid or not ready are ignored
    send(OP_WAIT, 4);
    bus.instr_valid = 1'b1;
    bus.opcode = OW'(OP_LDSW);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.opcode = OW'(i);
      bus.operand = WW'(15 - i);
      @(negedge clk);
    end
    idle(1);

    // Reset in the second cycle of WAIT 5
    send(OP_WAIT, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_pcw", bus.PC_wait, 0);
    check("rstw_busy", bus.busy, 0);
    check("rstw_rdy", bus.instr_ready, 1);
    idle(1);

    // Reset between LD and WR
    send(OP_LDSW, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstl_add", bus.ALU_add, 0);
    check("rstl_wr", bus.wr_res, 0);
    idle(1);

    // Reset beats a simultaneous accept
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode = OW'(OP_MOV);
    @(negedge clk);
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    check("rsta_add", bus.ALU_add, 0);
    check("rsta_rdy", bus.instr_ready, 1);
    @(negedge clk);
    check("rsta_after_add", bus.ALU_add, 0);
    check("rsta_after_busy", bus.busy, 0);

    // Undefined opcode
    send(OP_BAD, 0);
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
    check("halt_ill", bus.illegal_op, 1);
    check("halt_rdy", bus.instr_ready, 0);
    bus.instr_valid = 1'b1;
    bus.opcode = OW'(OP_MOV);
    repeat (3) @(negedge clk);
    bus.instr_valid = 1'b0;
    check("halt_ill_sticky", bus.illegal_op, 1);
    check("halt_rdy_sticky", bus.instr_ready, 0);
    check("halt_add", bus.ALU_add, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("halt_rst_ill", bus.illegal_op, 0);
    check("halt_rst_rdy", bus.instr_ready, 1);
`else
    check("nop_ill", bus.illegal_op, 1);
    check("nop_rdy", bus.instr_ready, 1);
    check("nop_en", bus.ALU_reg_en, 0);
    @(negedge clk);
    check("nop_after_ill", bus.illegal_op, 0);
    check("nop_after_busy", bus.busy, 0);
    send(OP_BAD, 0);
    send(OP_MOV, 0);
    check("nop_mov_ill", bus.illegal_op, 0);
    check("nop_mov_add", bus.ALU_add, 1);
`endif
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
